// File: rtl/mmio_uart_tx.sv
// Memory-mapped UART transmitter: byte FIFO feeding an LSB-first serialiser.
// The frame is 8N1 on an idle-high line.
// Optional feature macro: UART_PARITY_EN adds an even-parity bit between the data and stop bits.
module mmio_uart_tx #(
  parameter int unsigned BAUD_DIVISOR = 868,
  parameter int unsigned FIFO_DEPTH   = 8
) (
  input  logic                          clk_i,
  input  logic                          rst_n_i,
  input  logic                          write_i,
  input  logic [7:0]                    write_data_i,
  input  logic                          clear_i,
  output logic                          tx_o,
  output logic                          busy_o,
  output logic                          full_o,
  output logic                          empty_o,
  output logic [$clog2(FIFO_DEPTH):0]   count_o,
  output logic                          overflow_o,
  output logic                          tx_done_o
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = $clog2(BAUD_DIVISOR);
  localparam logic [CntW-1:0] BaudReload = CntW'(BAUD_DIVISOR - 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
`ifdef UART_PARITY_EN
    StParity,
`endif
    StStop
  } state_e;

  state_e          state_q;
  logic [CntW-1:0] baud_cnt_q;
  logic [2:0]      bit_idx_q;
  logic [7:0]      data_q;
  logic            tx_q;
  logic            tx_done_q;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [PtrW:0]   wr_ptr_q, rd_ptr_q;
  logic [7:0]      mem_q [FIFO_DEPTH];
  logic            overflow_q;

  logic [PtrW:0]   count;
  logic            empty, full, baud_done, pop, push;
  logic [7:0]      head;
  logic [2:0]      bit_idx_nxt;

  // FIFO status, pop/push decisions and the byte at the head of the queue
  always_comb begin
    count       = wr_ptr_q - rd_ptr_q;
    empty       = (count == '0);
    full        = (count == (PtrW + 1)'(FIFO_DEPTH));
    baud_done   = (baud_cnt_q == '0);
    head        = mem_q[rd_ptr_q[PtrW-1:0]];
    bit_idx_nxt = bit_idx_q + 3'd1;
    // The serialiser pops when idle, or when a stop bit ends with more data queued.
    pop         = !empty && ((state_q == StIdle) || ((state_q == StStop) && baud_done));
    // A pop in the same cycle frees the slot a full FIFO needs; clear drops the byte.
    push        = write_i && !clear_i && (!full || pop);
  end

  // FIFO pointers and the sticky overflow flag
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      // Clear flushes everything still queued; a same-cycle pop has already taken the head.
      if (clear_i) begin
        rd_ptr_q <= wr_ptr_q;
      end else if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      if (clear_i) begin
        overflow_q <= 1'b0;
      end else if (write_i && full && !pop) begin
        overflow_q <= 1'b1;
      end
    end
  end

  // FIFO storage; contents are only observable through the pointers, so no reset
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q[PtrW-1:0]] <= write_data_i;
    end
  end

  // Serialiser FSM with registered line and done pulse
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= StIdle;
      baud_cnt_q <= '0;
      bit_idx_q  <= '0;
      data_q     <= '0;
      tx_q       <= 1'b1;
      tx_done_q  <= 1'b0;
    end else begin
      tx_done_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (!empty) begin
            state_q    <= StStart;
            data_q     <= head;
            tx_q       <= 1'b0;
            baud_cnt_q <= BaudReload;
          end
        end
        StStart: begin
          if (baud_done) begin
            state_q    <= StData;
            bit_idx_q  <= '0;
            tx_q       <= data_q[0];
            baud_cnt_q <= BaudReload;
          end else begin
            baud_cnt_q <= baud_cnt_q - CntW'(1);
          end
        end
        StData: begin
          if (baud_done) begin
            baud_cnt_q <= BaudReload;
            if (bit_idx_q == 3'd7) begin
`ifdef UART_PARITY_EN
              state_q <= StParity;
              tx_q    <= ^data_q;
`else
              state_q <= StStop;
              tx_q    <= 1'b1;
`endif
            end else begin
              bit_idx_q <= bit_idx_nxt;
              tx_q      <= data_q[bit_idx_nxt];
            end
          end else begin
            baud_cnt_q <= baud_cnt_q - CntW'(1);
          end
        end
`ifdef UART_PARITY_EN
        StParity: begin
          if (baud_done) begin
            state_q    <= StStop;
            tx_q       <= 1'b1;
            baud_cnt_q <= BaudReload;
          end else begin
            baud_cnt_q <= baud_cnt_q - CntW'(1);
          end
        end
`endif
        StStop: begin
          if (baud_done) begin
            if (!empty) begin
              // Back-to-back frame: straight into the next start bit.
              state_q    <= StStart;
              data_q     <= head;
              tx_q       <= 1'b0;
              baud_cnt_q <= BaudReload;
            end else begin
              state_q   <= StIdle;
              tx_done_q <= 1'b1;
            end
          end else begin
            baud_cnt_q <= baud_cnt_q - CntW'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign tx_o       = tx_q;
  assign tx_done_o  = tx_done_q;
  assign busy_o     = (state_q != StIdle);
  assign full_o     = full;
  assign empty_o    = empty;
  assign count_o    = count;
  assign overflow_o = overflow_q;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Bench for mmio_uart_tx: random bytes checked against a frame-level model of the serial line.
module tb_mmio_uart_tx;

  localparam int BAUD  = 4;
  localparam int DEPTH = 8;
`ifdef UART_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FL   = NBITS * BAUD;
  // Log samples on falling edges, enabled just before the first write edge.
  localparam int LEAD = 2;

  logic       clk_i = 1'b0;
  logic       rst_n_i;
  logic       write_i;
  logic [7:0] write_data_i;
  logic       clear_i;
  logic       tx_o, busy_o, full_o, empty_o, overflow_o, tx_done_o;
  logic [3:0] count_o;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] sent_q[$];
  logic       exp_tx[$];
  logic       exp_done[$];
  logic       tx_log[$];
  logic       done_log[$];
  bit         log_en = 1'b0;
  int         log_len = 0;

  mmio_uart_tx #(
    .BAUD_DIVISOR(BAUD),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .write_i     (write_i),
    .write_data_i(write_data_i),
    .clear_i     (clear_i),
    .tx_o        (tx_o),
    .busy_o      (busy_o),
    .full_o      (full_o),
    .empty_o     (empty_o),
    .count_o     (count_o),
    .overflow_o  (overflow_o),
    .tx_done_o   (tx_done_o)
  );

  always #5 clk_i = ~clk_i;

  always @(negedge clk_i) begin
    if (log_en && tx_log.size() < log_len) begin
      tx_log.push_back(tx_o);
      done_log.push_back(tx_done_o);
    end
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Bit k of the serial frame carrying byte b.
  function automatic logic frame_bit(input logic [7:0] b, input int k);
    if (k == 0) return 1'b0;
    if (k <= 8) return b[k-1];
    if (k == 9 && NBITS == 11) return ^b;
    return 1'b1;
  endfunction

  // Expected line and done pulse: idle lead, contiguous frames for sent_q, one pulse after.
  task automatic build_model(input int len);
    int pulse_at;
    exp_tx.delete();
    exp_done.delete();
    for (int i = 0; i < LEAD; i++) begin
      exp_tx.push_back(1'b1);
      exp_done.push_back(1'b0);
    end
    foreach (sent_q[i])
      for (int k = 0; k < NBITS; k++)
        for (int c = 0; c < BAUD; c++) begin
          exp_tx.push_back(frame_bit(sent_q[i], k));
          exp_done.push_back(1'b0);
        end
    pulse_at = exp_tx.size();
    while (exp_tx.size() < len) begin
      exp_tx.push_back(1'b1);
      exp_done.push_back(exp_tx.size() == pulse_at + 1);
    end
  endtask

  task automatic start_log(input int len);
    tx_log.delete();
    done_log.delete();
    log_len = len;
    build_model(len);
    log_en  = 1'b1;
  endtask

  task automatic wait_log();
    int guard = 0;
    while (tx_log.size() < log_len && guard < log_len + 20) begin
      step();
      guard++;
    end
    log_en = 1'b0;
  endtask

  task automatic test_reset();
    rst_n_i = 1'b0; write_i = 1'b0; write_data_i = '0; clear_i = 1'b0;
    repeat (3) step();
    n_checks++;
    if (tx_o !== 1'b1 || busy_o !== 1'b0 || empty_o !== 1'b1 || full_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_line: tx=%b busy=%b empty=%b full=%b, expected 1 0 1 0",
               tx_o, busy_o, empty_o, full_o);
    end
    n_checks++;
    if (count_o !== 4'd0 || overflow_o !== 1'b0 || tx_done_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_status: count=%0d ovf=%b done=%b, expected 0 0 0",
               count_o, overflow_o, tx_done_o);
    end
    #3 rst_n_i = 1'b1;
    repeat (2) step();
    n_checks++;
    if (tx_o !== 1'b1 || busy_o !== 1'b0 || empty_o !== 1'b1 || count_o !== 4'd0) begin
      n_fail++;
      $display("FAIL after_reset: tx=%b busy=%b empty=%b count=%0d, expected 1 0 1 0",
               tx_o, busy_o, empty_o, count_o);
    end
  endtask

  task automatic test_single();
    logic [7:0] bytes[$];
    bytes.push_back(8'hA5);
`ifdef UART_PARITY_EN
    bytes.push_back(8'h07);
    bytes.push_back(8'h03);
`endif
    bytes.push_back(8'($urandom));
    bytes.push_back(8'($urandom));
    foreach (bytes[j]) begin
      sent_q.delete();
      sent_q.push_back(bytes[j]);
      start_log(LEAD + FL + 3);
      write_i = 1'b1; write_data_i = bytes[j];
      step();
      write_i = 1'b0;
      wait_log();
      n_checks++;
      if (tx_log.size() != log_len) begin
        n_fail++;
        $display("FAIL single_len: got %0d samples, expected %0d", tx_log.size(), log_len);
      end
      foreach (tx_log[i]) begin
        n_checks++;
        if (tx_log[i] !== exp_tx[i] || done_log[i] !== exp_done[i]) begin
          n_fail++;
          $display("FAIL single_frame byte=%h cycle %0d: tx=%b done=%b, expected tx=%b done=%b",
                   bytes[j], i, tx_log[i], done_log[i], exp_tx[i], exp_done[i]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int r = 0; r < 2; r++) begin
      sent_q.delete();
      if (r == 0) begin
        sent_q.push_back(8'h00); sent_q.push_back(8'hFF); sent_q.push_back(8'h55);
      end else begin
        for (int i = 0; i < 3; i++) sent_q.push_back(8'($urandom));
      end
      start_log(LEAD + 3 * FL + 3);
      foreach (sent_q[i]) begin
        write_i = 1'b1; write_data_i = sent_q[i];
        step();
      end
      write_i = 1'b0;
      wait_log();
      n_checks++;
      if (tx_log.size() != log_len) begin
        n_fail++;
        $display("FAIL b2b_len: got %0d samples, expected %0d", tx_log.size(), log_len);
      end
      foreach (tx_log[i]) begin
        n_checks++;
        if (tx_log[i] !== exp_tx[i] || done_log[i] !== exp_done[i]) begin
          n_fail++;
          $display("FAIL b2b_stream run %0d cycle %0d: tx=%b done=%b, expected tx=%b done=%b",
                   r, i, tx_log[i], done_log[i], exp_tx[i], exp_done[i]);
        end
      end
    end
  endtask

  // Fill the FIFO, then write exactly as the first frame's stop bit pops the next byte.
  task automatic test_full_pop();
    logic [7:0] extra;
    sent_q.delete();
    for (int i = 0; i < 9; i++) sent_q.push_back(8'($urandom));
    extra = 8'($urandom);
    sent_q.push_back(extra);
    start_log(LEAD + 10 * FL + 3);
    for (int i = 0; i < 9; i++) begin
      write_i = 1'b1; write_data_i = sent_q[i];
      step();
    end
    write_i = 1'b0;
    n_checks++;
    if (full_o !== 1'b1 || count_o !== 4'd8 || overflow_o !== 1'b0) begin
      n_fail++;
      $display("FAIL fill: full=%b count=%0d ovf=%b, expected 1 8 0", full_o, count_o, overflow_o);
    end
    // Now just after edge 8; the first stop bit expires at edge FL+1.
    repeat (FL - 8) step();
    write_i = 1'b1; write_data_i = extra;
    step();
    write_i = 1'b0;
    n_checks++;
    if (full_o !== 1'b1 || count_o !== 4'd8 || overflow_o !== 1'b0) begin
      n_fail++;
      $display("FAIL full_pop_push: full=%b count=%0d ovf=%b, expected 1 8 0",
               full_o, count_o, overflow_o);
    end
    wait_log();
    n_checks++;
    if (tx_log.size() != log_len) begin
      n_fail++;
      $display("FAIL full_pop_len: got %0d samples, expected %0d", tx_log.size(), log_len);
    end
    foreach (tx_log[i]) begin
      n_checks++;
      if (tx_log[i] !== exp_tx[i] || done_log[i] !== exp_done[i]) begin
        n_fail++;
        $display("FAIL full_pop_stream cycle %0d: tx=%b done=%b, expected tx=%b done=%b",
                 i, tx_log[i], done_log[i], exp_tx[i], exp_done[i]);
      end
    end
  endtask

  task automatic test_overflow_clear();
    int steps;
    for (int i = 0; i < 10; i++) begin
      write_i = 1'b1; write_data_i = 8'($urandom);
      step();
    end
    write_i = 1'b0;
    n_checks++;
    if (full_o !== 1'b1 || count_o !== 4'd8 || overflow_o !== 1'b1) begin
      n_fail++;
      $display("FAIL overflow: full=%b count=%0d ovf=%b, expected 1 8 1",
               full_o, count_o, overflow_o);
    end
    clear_i = 1'b1;
    step();
    n_checks++;
    if (count_o !== 4'd0 || overflow_o !== 1'b0 || empty_o !== 1'b1 || busy_o !== 1'b1) begin
      n_fail++;
      $display("FAIL clear: count=%0d ovf=%b empty=%b busy=%b, expected 0 0 1 1",
               count_o, overflow_o, empty_o, busy_o);
    end
    write_i = 1'b1; write_data_i = 8'($urandom);
    step();
    write_i = 1'b0; clear_i = 1'b0;
    n_checks++;
    if (count_o !== 4'd0 || overflow_o !== 1'b0 || empty_o !== 1'b1) begin
      n_fail++;
      $display("FAIL clear_and_write: count=%0d ovf=%b empty=%b, expected 0 0 1",
               count_o, overflow_o, empty_o);
    end
    // Now just after edge 11; the first frame's done pulse lands on edge FL+1.
    steps = 0;
    while (tx_done_o !== 1'b1 && steps < 2 * FL) begin
      step();
      steps++;
    end
    n_checks++;
    if (steps != FL - 10) begin
      n_fail++;
      $display("FAIL clear_frame_done: done after %0d cycles, expected %0d", steps, FL - 10);
    end
    repeat (3) step();
    n_checks++;
    if (busy_o !== 1'b0 || tx_o !== 1'b1 || tx_done_o !== 1'b0) begin
      n_fail++;
      $display("FAIL clear_idle: busy=%b tx=%b done=%b, expected 0 1 0", busy_o, tx_o, tx_done_o);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] b;
    b = 8'($urandom) & 8'hF7;
    write_i = 1'b1; write_data_i = b;
    step();
    write_i = 1'b1; write_data_i = 8'($urandom);
    step();
    write_i = 1'b0;
    // Just after the falling edge of the start bit; data bit 3 spans cycles 16..19.
    repeat (17) step();
    n_checks++;
    if (tx_o !== 1'b0 || count_o !== 4'd1 || busy_o !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_reset: tx=%b count=%0d busy=%b, expected 0 1 1", tx_o, count_o, busy_o);
    end
    #2 rst_n_i = 1'b0;
    #1;
    n_checks++;
    if (tx_o !== 1'b1 || count_o !== 4'd0 || busy_o !== 1'b0 || empty_o !== 1'b1) begin
      n_fail++;
      $display("FAIL async_reset: tx=%b count=%0d busy=%b empty=%b, expected 1 0 0 1",
               tx_o, count_o, busy_o, empty_o);
    end
    #2 rst_n_i = 1'b1;
    repeat (3) step();
    n_checks++;
    if (tx_o !== 1'b1 || busy_o !== 1'b0 || tx_done_o !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset_idle: tx=%b busy=%b done=%b, expected 1 0 0",
               tx_o, busy_o, tx_done_o);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_full_pop();
    test_overflow_clear();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
